// File: rtl/prescaler_prog.sv
// prescaler_prog: programmable double-buffered clock-enable prescaler with start/stop and one-shot mode
// Ports:
//   clk      system clock, all state on rising edge
//   clr_n    asynchronous active-low reset
//   ce       count enable
//   clr      synchronous clear
//   start    begin/restart counting (single-cycle pulse)
//   stop     abort counting (single-cycle pulse, wins over start)
//   mode     0 = periodic, 1 = one-shot; sampled on start
//   div_load write div_val into the shadow divide register
//   div_val  new divide value
//   co       registered terminal pulse, one clk wide, every active+1 enabled clocks
//   busy     high while running
//   count    current counter value
//   clk_div  toggle output, only live when PRESCALER_TOGGLE_EN is defined (else tied to 0)
module prescaler_prog #(
   parameter int WIDTH = 20,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = '1
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             ce,
   input  logic             clr,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_val,
   output logic             co,
   output logic             busy,
   output logic [WIDTH-1:0] count,
   output logic             clk_div
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [WIDTH-1:0] shadow, active, shadow_nxt;
   logic mode_q, term, fire;
   // a load on the same edge as a reload point bypasses straight into active
   assign shadow_nxt = div_load ? div_val : shadow;
   assign term = state == RUN && ce && count == active;
   assign fire = term && !clr && !stop && !start;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         co     <= 1'b0;
         count  <= '0;
         mode_q <= 1'b0;
         shadow <= DEFAULT_DIV;
         active <= DEFAULT_DIV;
      end else begin
         shadow <= shadow_nxt;
         if (clr) begin
            state  <= IDLE;
            busy   <= 1'b0;
            co     <= 1'b0;
            count  <= '0;
            active <= shadow_nxt;
         end else if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            co    <= 1'b0;
            count <= '0;
         end else if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            co     <= 1'b0;
            count  <= '0;
            mode_q <= mode;
            active <= shadow_nxt;
         end else if (fire) begin
            co     <= 1'b1;
            count  <= '0;
            active <= shadow_nxt;
            if (mode_q) begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else begin
            co <= 1'b0;
            if (state == RUN && ce) count <= count + 1'b1;
         end
      end
`ifdef PRESCALER_TOGGLE_EN
   logic tog;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) tog <= 1'b0;
      else if (fire) tog <= ~tog;
   assign clk_div = tog;
`else
   assign clk_div = 1'b0;
`endif
endmodule

// File: tb/tb_prescaler_prog.sv
// tb_prescaler_prog: table-driven, directed and randomized checks of prescaler_prog against a behavioural model
module tb_prescaler_prog;
   localparam int W = 4;
   logic clk = 0, clr_n = 0, ce = 0, clr = 0, start = 0, stop = 0, mode = 0, div_load = 0;
   logic [W-1:0] div_val = '0;
   logic co, busy, clk_div;
   logic [W-1:0] count;
   int checks = 0, errors = 0, cyc_n = 0;

   prescaler_prog #(.WIDTH(W)) dut (
      .clk(clk), .clr_n(clr_n), .ce(ce), .clr(clr), .start(start), .stop(stop), .mode(mode),
      .div_load(div_load), .div_val(div_val), .co(co), .busy(busy), .count(count), .clk_div(clk_div)
   );

   always #5 clk = ~clk;

   // model: counts the enabled clocks still left before the terminal pulse
   int m_sh, m_act, m_left;
   bit m_run, m_mode, m_co, m_tog;

   function automatic void model_reset();
      m_sh = 2**W - 1; m_act = m_sh; m_left = m_sh;
      m_run = 0; m_mode = 0; m_co = 0; m_tog = 0;
   endfunction

   function automatic void model_edge();
      int nsh;
      nsh = div_load ? int'(div_val) : m_sh;
      if (clr) begin m_run = 0; m_co = 0; m_act = nsh; end
      else if (stop) begin m_run = 0; m_co = 0; end
      else if (start) begin m_run = 1; m_mode = mode; m_act = nsh; m_left = nsh; m_co = 0; end
      else if (m_run && ce) begin
         if (m_left == 0) begin
            m_co = 1; m_tog = !m_tog; m_act = nsh; m_left = nsh;
            if (m_mode) m_run = 0;
         end else begin
            m_left--; m_co = 0;
         end
      end else m_co = 0;
      m_sh = nsh;
   endfunction

   function automatic int exp_count();
      return m_run ? m_act - m_left : 0;
   endfunction

   function automatic bit exp_clk_div();
`ifdef PRESCALER_TOGGLE_EN
      return m_tog;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_n, act, exp);
      end
   endtask

   task automatic chk_model();
      chk("co", 32'(co), 32'(m_co));
      chk("busy", 32'(busy), 32'(m_run));
      chk("count", 32'(count), 32'(exp_count()));
      chk("clk_div", 32'(clk_div), 32'(exp_clk_div()));
   endtask

   task automatic step(input logic st, sp, md, c, cl, dl, input logic [W-1:0] dv);
      start = st; stop = sp; mode = md; ce = c; clr = cl; div_load = dl; div_val = dv;
      model_edge();
      @(posedge clk);
      #1;
      cyc_n++;
      chk_model();
   endtask

   task automatic run1(input logic c);
      step(0, 0, 0, c, 0, 0, '0);
   endtask

   task automatic async_rst();
      #2 clr_n = 0;
      model_reset();
      #1;
      chk("rst_co", 32'(co), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_clk_div", 32'(clk_div), 0);
      #2 clr_n = 1;
   endtask

   typedef struct {
      logic st, sp, md, c, cl, dl;
      logic [W-1:0] dv;
      logic e_co, e_busy;
      logic [W-1:0] e_count;
   } vec_t;

   function automatic vec_t v(input logic st, sp, md, c, cl, dl, input int dv, input logic eco, ebusy, input int ecnt);
      vec_t r;
      r.st = st; r.sp = sp; r.md = md; r.c = c; r.cl = cl; r.dl = dl; r.dv = W'(dv);
      r.e_co = eco; r.e_busy = ebusy; r.e_count = W'(ecnt);
      return r;
   endfunction

   vec_t tbl[$];
   int pulses[$];
   int t0;

   initial begin
      model_reset();
      #3;
      chk("reset_co", 32'(co), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_count", 32'(count), 0);
      chk("reset_clk_div", 32'(clk_div), 0);
      @(posedge clk); #1 clr_n = 1;

      // periodic div 4
      tbl.push_back(v(0,0,0,1,0,1,4, 0,0,0));
      tbl.push_back(v(1,0,0,1,0,0,0, 0,1,0));
      for (int i = 1; i <= 4; i++) tbl.push_back(v(0,0,0,1,0,0,0, 0,1,i));
      tbl.push_back(v(0,0,0,1,0,0,0, 1,1,0));
      for (int i = 1; i <= 4; i++) tbl.push_back(v(0,0,0,1,0,0,0, 0,1,i));
      tbl.push_back(v(0,0,0,1,0,0,0, 1,1,0));
      // stop, then one-shot div 3
      tbl.push_back(v(0,1,0,1,0,0,0, 0,0,0));
      tbl.push_back(v(0,0,0,1,0,1,3, 0,0,0));
      tbl.push_back(v(1,0,1,1,0,0,0, 0,1,0));
      for (int i = 1; i <= 3; i++) tbl.push_back(v(0,0,0,1,0,0,0, 0,1,i));
      tbl.push_back(v(0,0,0,1,0,0,0, 1,0,0));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,0,0));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,0,0));
      // start+stop while idle stays idle
      tbl.push_back(v(1,1,0,1,0,0,0, 0,0,0));
      // div_load coinciding with start goes straight to active
      tbl.push_back(v(1,0,0,1,0,1,1, 0,1,0));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,1,1));
      tbl.push_back(v(0,0,0,1,0,0,0, 1,1,0));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,1,1));
      tbl.push_back(v(0,0,0,1,0,0,0, 1,1,0));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,1,1));
      // restart at a terminal suppresses co
      tbl.push_back(v(1,0,0,1,0,0,0, 0,1,0));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,1,1));
      tbl.push_back(v(0,0,0,1,0,0,0, 1,1,0));
      // clr with div_load, then run div 2 with ce gaps at the terminal
      tbl.push_back(v(0,0,0,1,1,1,2, 0,0,0));
      tbl.push_back(v(1,0,0,1,0,0,0, 0,1,0));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,1,1));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,1,2));
      tbl.push_back(v(0,0,0,1,0,0,0, 1,1,0));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,1,1));
      tbl.push_back(v(0,0,0,1,0,0,0, 0,1,2));
      tbl.push_back(v(0,0,0,0,0,0,0, 0,1,2));
      tbl.push_back(v(0,0,0,0,0,0,0, 0,1,2));
      tbl.push_back(v(0,0,0,1,0,0,0, 1,1,0));
      tbl.push_back(v(0,0,0,0,0,0,0, 0,1,0));
      tbl.push_back(v(0,1,0,1,0,0,0, 0,0,0));
      foreach (tbl[i]) begin
         step(tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].c, tbl[i].cl, tbl[i].dl, tbl[i].dv);
         chk($sformatf("tbl%0d_co", i), 32'(co), 32'(tbl[i].e_co));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      end

      // div 9 with ce alternating: one pulse every 20 clocks
      step(0, 0, 0, 1, 0, 1, 9);
      step(1, 0, 0, 1, 0, 0, 0);
      t0 = cyc_n; pulses.delete();
      for (int i = 0; i < 70; i++) begin
         run1(i % 2 == 0);
         if (co) pulses.push_back(cyc_n - t0);
      end
      chk("ce_half_pulses", 32'(pulses.size()), 3);
      for (int i = 1; i < pulses.size(); i++) chk("ce_half_gap", 32'(pulses[i] - pulses[i-1]), 20);

      // reload mid-period: current period completes at 7, then period 3
      step(0, 0, 0, 1, 0, 1, 7);
      step(1, 0, 0, 1, 0, 0, 0);
      t0 = cyc_n; pulses.delete();
      for (int i = 0; i < 3; i++) run1(1);
      chk("reload_at3", 32'(count), 3);
      step(0, 0, 0, 1, 0, 1, 2);
      for (int i = 0; i < 11; i++) begin
         run1(1);
         if (co) pulses.push_back(cyc_n - t0);
      end
      chk("reload_pulses", 32'(pulses.size()), 3);
      if (pulses.size() == 3) begin
         chk("reload_p0", 32'(pulses[0]), 8);
         chk("reload_p1", 32'(pulses[1]), 11);
         chk("reload_p2", 32'(pulses[2]), 14);
      end

      // async reset mid-run at count 5, then default divide gives full wrap
      step(0, 0, 0, 1, 0, 1, 9);
      step(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) run1(1);
      chk("pre_rst_count", 32'(count), 5);
      async_rst();
      step(1, 0, 0, 1, 0, 0, 0);
      t0 = cyc_n; pulses.delete();
      for (int i = 0; i < 33; i++) begin
         run1(1);
         if (i == 14) chk("wrap_top", 32'(count), 15);
         if (co) pulses.push_back(cyc_n - t0);
      end
      chk("wrap_pulses", 32'(pulses.size()), 2);
      if (pulses.size() == 2) chk("wrap_p0", 32'(pulses[0]), 16);

      // divide by 1 periodic, then divide by 2 for the toggle output
      step(0, 0, 0, 1, 0, 1, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         run1(1);
         chk("div1_co", 32'(co), 1);
      end
      step(1, 0, 0, 1, 0, 1, 1);
      for (int i = 0; i < 12; i++) run1(1);

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) async_rst();
         step($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
              W'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/prescaler_prog.md
Name: prescaler_prog

Overview:
- Programmable, parametrised clock-enable prescaler for the lock design.
- Produces a one-cycle terminal pulse every div+1 enabled clocks.
- Divide value is runtime-loadable and double-buffered, so reloads never shorten a period in flight.
- Runs in periodic or one-shot mode under a start/stop handshake; feeds debounce, keypad-scan and timeout logic.

Parameters:
- WIDTH, 20, counter and divide-value width in bits.
- DEFAULT_DIV, 2**WIDTH-1, divide value loaded into shadow and active registers at reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- ce  in  1  count enable; counter advances only when high.
- clr  in  1  synchronous clear, active high.
- start  in  1  single-cycle pulse: begin/restart counting.
- stop  in  1  single-cycle pulse: abort counting.
- mode  in  1  0 = periodic, 1 = one-shot; sampled on start.
- div_load  in  1  write div_val into the shadow register.
- div_val  in  WIDTH  new divide value.
- co  out  1  registered terminal pulse, one clk wide.
- busy  out  1  high while state is RUN.
- count  out  WIDTH  current counter value.
- clk_div  out  1  toggle output (see Optional Feature).

Behaviour:
- Reset (clr_n low, async):
  - count=0, state=IDLE, co=0, busy=0, clk_div=0, mode_q=0.
  - shadow=active=DEFAULT_DIV.
- Sync clr: count=0, state=IDLE, co=0, active<=shadow; shadow keeps its value. Priority below clr_n, above all other inputs.
- FSM has two states, IDLE and RUN.
  - IDLE: count holds 0, co=0. On start: state->RUN, count<=0, mode_q<=mode, active<=shadow.
  - RUN, ce=1, count!=active: count<=count+1.
  - RUN, ce=1, count==active (terminal): co<=1 for the next cycle, count<=0, active<=shadow. Then stay RUN if mode_q=0; go to IDLE if mode_q=1.
  - RUN, ce=0: count holds, co<=0; a pending terminal is not consumed.
- Timing: with ce held high and start at edge 0, co is high after edge active+1. Period is active+1 clk cycles, one co pulse per period.
- active=0: co high every enabled cycle in periodic mode (divide by 1).
- active=2**WIDTH-1: full wrap, period 2**WIDTH; no overflow beyond the terminal value.
- stop in RUN: state->IDLE, count<=0, co<=0 on that edge.
- Simultaneous start and stop: stop wins.
- start in RUN: restart with count<=0, mode_q<=mode, active<=shadow. No co on that edge even if count==active.
- div_load: shadow<=div_val on any edge (not blocked by ce or state). It does not affect the current period.
- div_load coinciding with a terminal, start or clr: the new div_val goes straight to active on that edge.
- busy = (state==RUN), registered.
- co is never high in IDLE except in the single cycle after a one-shot terminal.

Optional Feature:
- Macro: PRESCALER_TOGGLE_EN.
- Defined: clk_div toggles on every edge where co is set to 1, giving a 50% duty square wave of period 2*(active+1) enabled cycles.
  - Reset by clr_n to 0.
  - Sync clr and stop hold its current level.
- Undefined: clk_div is tied to 0 and the toggle flop is removed; port list is unchanged.

Test Plan:
- Reset, start, mode=0, ce=1, div_load div_val=4 before start -> co pulses every 5 clk cycles, busy=1, count cycles 0..4.
- mode=1, div=3, start -> exactly one co pulse 4 cycles after start, then busy=0, count=0; no further pulses.
- Periodic, div=9, ce toggled 1/0 alternately -> co every 20 clk cycles; count holds on ce=0 cycles.
- Running div=7, div_load 2 mid-period at count=3 -> current period completes at 7, following periods are 3 cycles.
- Start and stop in the same cycle while IDLE -> stays IDLE; clr_n pulsed low mid-RUN at count=5 -> count=0, co=0, busy=0 immediately, shadow=DEFAULT_DIV.
- With PRESCALER_TOGGLE_EN, div=1, periodic -> clk_div period 4 cycles, 50% duty; without the macro -> clk_div constant 0.
